// File: rtl/nn_fixed_pkg.sv
// rtl/nn_fixed_pkg.sv - shared fixed-point types and constants for NN backward blocks
package nn_fixed_pkg;

  localparam int INT_BIT_DEF  = 7;
  localparam int FRAC_BIT_DEF = 8;
  localparam int M            = FRAC_BIT_DEF + 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL1,
    MUL2,
    DONE
  } sigbwd_state_t;

  function automatic int unsigned one_q(input int unsigned frac_bit);
    return 32'd1 << frac_bit;
  endfunction

endpackage

// File: rtl/seq_shift_add_mul.sv
// rtl/seq_shift_add_mul.sv - sequential shift-add multiplier, one multiplier bit per clock, LSB first
// o_product is the running sum including the current step; it is final in the cycle o_done is high.
module seq_shift_add_mul #(
  parameter int A_W = 16,
  parameter int M_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_signed,
  input  logic [A_W-1:0]     i_mcand,
  input  logic [M_W-1:0]     i_mplier,
  output logic               o_busy,
  output logic               o_done,
  output logic [A_W+M_W-1:0] o_product
);

  localparam int P_W = A_W + M_W;
  localparam int CW  = $clog2(M_W + 1);

  logic [P_W-1:0] r_mcand;
  logic [P_W-1:0] r_acc;
  logic [M_W-1:0] r_mplier;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;

  logic [P_W-1:0] w_ext;
  logic [P_W-1:0] w_cur_mcand;
  logic [P_W-1:0] w_cur_acc;
  logic [P_W-1:0] w_sum;
  logic           w_cur_bit;

  // The start cycle already consumes multiplier bit 0, so a product takes exactly M_W clocks.
  assign w_ext       = i_signed ? {{M_W{i_mcand[A_W-1]}}, i_mcand} : {{M_W{1'b0}}, i_mcand};
  assign w_cur_mcand = i_start ? w_ext : r_mcand;
  assign w_cur_bit   = i_start ? i_mplier[0] : r_mplier[0];
  assign w_cur_acc   = i_start ? '0 : r_acc;
  assign w_sum       = w_cur_acc + (w_cur_bit ? w_cur_mcand : '0);

  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_cnt == CW'(M_W - 1));
  assign o_product = w_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= w_sum;
      r_mcand  <= w_ext << 1;
      r_mplier <= i_mplier >> 1;
      r_cnt    <= CW'(1);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (o_done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sigmoid_backward.sv
// rtl/sigmoid_backward.sv - sigmoid backward pass: grad_out = g * s * (1 - s)
// One shared multiplier: MUL1 forms d = s*(1-s), MUL2 forms g*d.
module sigmoid_backward
  import nn_fixed_pkg::*;
#(
  parameter int INT_BIT  = INT_BIT_DEF,
  parameter int FRAC_BIT = FRAC_BIT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FRAC_BIT:0]           s_in,
  input  logic [INT_BIT+FRAC_BIT:0]   g_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INT_BIT+FRAC_BIT:0]   grad_out
);

  localparam int W   = INT_BIT + FRAC_BIT + 1;
  localparam int MW  = FRAC_BIT + 1;
  localparam int P_W = W + MW;
  localparam logic [MW-1:0] ONE = MW'(one_q(FRAC_BIT));

  sigbwd_state_t r_state;
  sigbwd_state_t w_state_nxt;

  logic [MW-1:0]  r_s;
  logic [MW-1:0]  r_d;
  logic [W-1:0]   r_g;
  logic [W-1:0]   r_grad;

  logic           w_start;
  logic           w_signed;
  logic [W-1:0]   w_mcand;
  logic [MW-1:0]  w_mplier;
  logic           w_busy;
  logic           w_done;
  logic [P_W-1:0] w_prod;
  logic           w_unused_prod;

  seq_shift_add_mul #(
    .A_W (W),
    .M_W (MW)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start),
    .i_signed  (w_signed),
    .i_mcand   (w_mcand),
    .i_mplier  (w_mplier),
    .o_busy    (w_busy),
    .o_done    (w_done),
    .o_product (w_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = MUL1;
      MUL1:    if (w_done)    w_state_nxt = MUL2;
      MUL2:    if (w_done)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    w_start   = ((r_state == MUL1) || (r_state == MUL2)) && !w_busy;
    w_signed  = (r_state == MUL2);
    w_mcand   = (r_state == MUL2) ? r_g : W'(r_s);
    w_mplier  = (r_state == MUL2) ? r_d : (ONE - r_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= '0;
      r_g    <= '0;
      r_d    <= '0;
      r_grad <= '0;
    end else begin
      if ((r_state == IDLE) && in_valid) begin
        r_s <= (s_in > ONE) ? ONE : s_in;
        r_g <= g_in;
      end
      if ((r_state == MUL1) && w_done) begin
        r_d <= w_prod[FRAC_BIT +: MW];
      end
      // Taking bits above FRAC_BIT of the signed product is the arithmetic shift (floor).
      if ((r_state == MUL2) && w_done) begin
        r_grad <= w_prod[FRAC_BIT +: W];
      end
    end
  end

  assign grad_out      = r_grad;
  assign w_unused_prod = ^{w_prod[P_W-1], w_prod[FRAC_BIT-1:0]};

endmodule

// File: tb/tb_sigmoid_backward.sv
// tb/tb_sigmoid_backward.sv - self-checking bench for sigmoid_backward
module tb_sigmoid_backward;
  import nn_fixed_pkg::*;

  localparam int INT_BIT  = 7;
  localparam int FRAC_BIT = 8;
  localparam int W        = INT_BIT + FRAC_BIT + 1;
  localparam int LAT      = 2 * M;
  localparam int PERIOD   = 2 * M + 2;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b1;
  logic [FRAC_BIT:0] s_in     = '0;
  logic [W-1:0]     g_in      = '0;
  logic             in_ready;
  logic             out_valid;
  logic [W-1:0]     grad_out;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  logic [W-1:0] exp_q[$];

  sigmoid_backward #(
    .INT_BIT  (INT_BIT),
    .FRAC_BIT (FRAC_BIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_in      (s_in),
    .g_in      (g_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grad_out  (grad_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] model(input logic [FRAC_BIT:0] s_raw, input logic [W-1:0] g);
    int     one;
    int     s;
    int     d;
    longint p;
    one = 1 << FRAC_BIT;
    s   = (int'(s_raw) > one) ? one : int'(s_raw);
    d   = (s * (one - s)) / one;
    p   = longint'($signed(g)) * longint'(d);
    return W'(p >>> FRAC_BIT);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_grad_out", 32'(grad_out), 32'd0);
    end else begin
      if (out_valid) begin
        check("result_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check("grad_vs_model", 32'(grad_out), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(s_in, g_in));
    end
  end

  // Called at posedge+#1 with the DUT idle.
  task automatic run_txn(input string nm, input logic [FRAC_BIT:0] s, input logic [W-1:0] g,
                         input logic [W-1:0] exp_lit, input int hold);
    int lat;
    check({nm, "_ready_before"}, 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    s_in      = s;
    g_in      = g;
    @(posedge clk); #1;
    in_valid = 1'b0;
    s_in     = ~s;
    g_in     = ~g;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, 32'(lat), 32'(LAT));
    check({nm, "_grad"}, 32'(grad_out), 32'(exp_lit));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({nm, "_hold_grad"}, 32'(grad_out), 32'(exp_lit));
      check({nm, "_hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({nm, "_idle_ready"}, 32'(in_ready), 32'd1);
    check({nm, "_idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int t_acc;
    int t_prev;
    int wt;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("init_in_ready", 32'(in_ready), 32'd1);
    check("init_out_valid", 32'(out_valid), 32'd0);
    check("init_grad", 32'(grad_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn("half_pos1",   9'h080, 16'h0100, 16'h0040, 0);
    run_txn("half_neg1",   9'h080, 16'hFF00, 16'hFFC0, 0);
    run_txn("half_neglsb", 9'h080, 16'hFFFF, 16'hFFFF, 0);
    run_txn("half_min",    9'h080, 16'h8000, 16'hE000, 0);
    run_txn("half_max",    9'h080, 16'h7FFF, 16'h1FFF, 0);
    run_txn("q3_two",      9'h0C0, 16'h0200, 16'h0060, 0);
    run_txn("s_zero",      9'h000, 16'h7FFF, 16'h0000, 0);
    run_txn("s_one",       9'h100, 16'h7FFF, 16'h0000, 0);
    run_txn("s_clamp",     9'h1FF, 16'h7FFF, 16'h0000, 0);
    run_txn("backpress",   9'h0C0, 16'h0200, 16'h0060, 10);

    // Abort mid-MUL2 while grad_out still holds a nonzero previous result.
    run_txn("pre_rst",     9'h080, 16'h7FFF, 16'h1FFF, 0);
    in_valid = 1'b1;
    s_in     = 9'h0C0;
    g_in     = 16'h8000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_grad", 32'(grad_out), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_txn("post_rst",    9'h0C0, 16'hFF00, 16'hFFD0, 0);

    out_ready = 1'b1;
    t_prev    = 0;
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'b1;
      s_in     = 9'($urandom_range(0, 511));
      g_in     = 16'($urandom);
      @(posedge clk); #1;
      t_acc = cyc;
      if (i > 0) check("b2b_spacing", 32'(t_acc - t_prev), 32'(PERIOD));
      t_prev = t_acc;
      wt = 0;
      while (!in_ready && wt < 100) begin
        @(posedge clk); #1;
        wt++;
      end
      check("b2b_ready_bound", 32'(in_ready), 32'd1);
      if (i == 999) in_valid = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
